// File: rtl/btb_table_pkg.sv
// Shared CPU package: branch direction encodings and BTB counter states.
// Counter init values and saturating update live here for reuse.
package btb_table_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } taken_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [1:0] CTR_INIT_TAKEN     = CTR_WT;
    localparam logic [1:0] CTR_INIT_NOT_TAKEN = CTR_WNT;

    function automatic logic [1:0] ctr_init(input taken_type_e t);
        return (t == TAKEN) ? CTR_INIT_TAKEN : CTR_INIT_NOT_TAKEN;
    endfunction

    function automatic logic [1:0] ctr_next(
        input logic [1:0]  c,
        input taken_type_e t
    );
        if (t == TAKEN)
            return (c == CTR_ST) ? c : c + 2'd1;
        else
            return (c == CTR_SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_match.sv
// Parallel tag compare across all entries.
// Emits the one-hot hit vector and the lowest matching index.
module btb_match
    import btb_table_pkg::*;
#(
    parameter int ENTRY_COUNT = 16,
    parameter int TAG_WIDTH   = 32,
    parameter int IDX_W       = $clog2(ENTRY_COUNT)
) (
    input  logic [ENTRY_COUNT-1:0]           valid,
    input  logic [ENTRY_COUNT*TAG_WIDTH-1:0] tags,
    input  logic [TAG_WIDTH-1:0]             key,
    output logic [ENTRY_COUNT-1:0]           hit_vec,
    output logic [IDX_W-1:0]                 hit_idx
);

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            hit_vec[i] = valid[i] &&
                (tags[i*TAG_WIDTH +: TAG_WIDTH] == key);
        end
    end

    // Walk downward so the lowest set index is assigned last.
    always_comb begin
        hit_idx = '0;
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (hit_vec[i])
                hit_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/btb_table.sv
// Fully-associative branch target buffer with 2-bit counters.
// Round-robin replacement; lookup is combinational from stored state.
module btb_table
    import btb_table_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int TAG_WIDTH   = 32,
    parameter int ENTRY_COUNT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                hit,
    output logic                taken_predicted,
    output logic [PC_WIDTH-1:0] predicted_target,
    input  logic                new_entry,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic [PC_WIDTH-1:0] upd_target,
    input  logic                upd_taken
);

    localparam int IDX_W = $clog2(ENTRY_COUNT);

    logic [ENTRY_COUNT-1:0]           valid_q;
    logic [TAG_WIDTH-1:0]             tag_q    [ENTRY_COUNT];
    logic [PC_WIDTH-1:0]              target_q [ENTRY_COUNT];
    logic [1:0]                       ctr_q    [ENTRY_COUNT];
    logic [IDX_W-1:0]                 vp;
    logic [ENTRY_COUNT*TAG_WIDTH-1:0] tag_flat;

    logic [ENTRY_COUNT-1:0] lk_vec;
    logic [IDX_W-1:0]       lk_idx;
    logic [ENTRY_COUNT-1:0] up_vec;
    logic [IDX_W-1:0]       up_idx;
    logic                   up_hit;
    logic [IDX_W-1:0]       wr_idx;
    taken_type_e            dir;

    always_comb begin
        tag_flat = '0;
        for (int i = 0; i < ENTRY_COUNT; i++)
            tag_flat[i*TAG_WIDTH +: TAG_WIDTH] = tag_q[i];
    end

    btb_match #(
        .ENTRY_COUNT(ENTRY_COUNT),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_lookup (
        .valid  (valid_q),
        .tags   (tag_flat),
        .key    (if_pc[TAG_WIDTH-1:0]),
        .hit_vec(lk_vec),
        .hit_idx(lk_idx)
    );

    btb_match #(
        .ENTRY_COUNT(ENTRY_COUNT),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_update (
        .valid  (valid_q),
        .tags   (tag_flat),
        .key    (upd_pc[TAG_WIDTH-1:0]),
        .hit_vec(up_vec),
        .hit_idx(up_idx)
    );

    assign up_hit = |up_vec;
    assign wr_idx = up_hit ? up_idx : vp;
    assign dir    = taken_type_e'(upd_taken);

    always_comb begin
        hit              = 1'b0;
        taken_predicted  = 1'b0;
        predicted_target = '0;
        if (!rst && |lk_vec) begin
            hit              = 1'b1;
            taken_predicted  = ctr_q[lk_idx][1];
            predicted_target = target_q[lk_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            vp      <= '0;
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_SNT;
            end
        end else if (new_entry) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= upd_pc[TAG_WIDTH-1:0];
            target_q[wr_idx] <= upd_target;
            ctr_q[wr_idx]    <= ctr_init(dir);
            if (!up_hit)
                vp <= vp + IDX_W'(1);
        end else if (upd_valid && up_hit) begin
            ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], dir);
            if (upd_taken)
                target_q[up_idx] <= upd_target;
        end
    end

endmodule

// File: doc/btb_table.md
BTB_TABLE -- requirements
Module: btb_table

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, instruction address width.
REQ-002 SHALL have parameter TAG_WIDTH, default 32, stored tag width; tag is pc[TAG_WIDTH-1:0].
REQ-003 SHALL have parameter ENTRY_COUNT, default 16, number of fully-associative entries; power of two, at least 2.
REQ-004 Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- if_pc  in  PC_WIDTH  fetch PC for lookup.
- hit  out  1  if_pc matches a valid entry.
- taken_predicted  out  1  counter MSB of the matching entry.
- predicted_target  out  PC_WIDTH  stored target of the matching entry.
- new_entry  in  1  allocate or overwrite an entry for upd_pc (from branch control).
- upd_valid  in  1  resolved branch that hit at fetch; train its counter.
- upd_pc  in  PC_WIDTH  PC of the resolved branch/jump.
- upd_target  in  PC_WIDTH  resolved target.
- upd_taken  in  1  resolved direction (1 = taken).

Function
REQ-005 Lookup SHALL be combinational from stored state: hit, taken_predicted and predicted_target update in the same cycle as if_pc.
REQ-006 On a miss, taken_predicted SHALL be 0 and predicted_target SHALL be 0.
REQ-007 Each entry SHALL hold valid (1b), tag (TAG_WIDTH), target (PC_WIDTH) and a 2-bit saturating counter.
REQ-008 Multiple matching entries SHALL be impossible by construction (REQ-010); if one occurs, the lowest index SHALL win.
REQ-009 On new_entry at a clock edge with upd_pc missing the table: write the entry at victim pointer vp with valid=1, tag, target, and counter 2'b10 if upd_taken, else 2'b01. Then vp SHALL advance by 1 modulo ENTRY_COUNT.
REQ-010 On new_entry with upd_pc already present: overwrite that entry's target and re-initialise its counter per REQ-009. vp SHALL be unchanged.
REQ-011 On upd_valid without new_entry, with upd_pc present: the counter SHALL increment if upd_taken and decrement otherwise, saturating at 2'b11 and 2'b00. The target SHALL be rewritten with upd_target only when upd_taken=1.
REQ-012 On upd_valid with upd_pc absent: no state change.
REQ-013 If new_entry and upd_valid are both high, new_entry SHALL take precedence.
REQ-014 Writes SHALL take effect at the clock edge. A same-cycle lookup of upd_pc SHALL return pre-write contents; there is no write-through bypass.
REQ-015 vp SHALL wrap from ENTRY_COUNT-1 to 0. Replacement is round-robin irrespective of valid bits.
REQ-016 At most one entry SHALL be written per cycle.

Reset
REQ-017 rst SHALL asynchronously clear all valid bits, all counters to 2'b00, and vp to 0. Tags and targets need not be reset.
REQ-018 While rst is high: hit=0, taken_predicted=0, predicted_target=0, and all updates are ignored.
REQ-019 Reset asserted mid-operation SHALL discard any write in that cycle.

Structure
REQ-020 Counter encodings (2'b00..2'b11) and their init values SHALL live in the shared CPU package beside the taken_type encodings.
REQ-021 One sub-module, btb_match, SHALL perform the parallel tag compare. It outputs a one-hot hit vector plus the lowest-index encoded hit, and is instantiated twice: once for lookup and once for update.

Verification
REQ-022 Reset then if_pc=0x100 -> hit=0, taken_predicted=0, predicted_target=0.
REQ-023 new_entry, upd_pc=0x100, upd_target=0x200, upd_taken=1 -> same cycle lookup of 0x100 still misses; next cycle hit=1, taken_predicted=1, predicted_target=0x200, vp=1.
REQ-024 Entry 0x100 at counter 2'b10; three upd_valid with upd_taken=0 -> counter 01, 00, 00; taken_predicted=0 from the first update on.
REQ-025 Allocate 17 distinct PCs 0x0,0x4,...,0x40 -> 0x0 evicted (miss); 0x4..0x40 hit; vp=1.
REQ-026 new_entry for existing 0x100 with upd_target=0x300, upd_taken=0 -> no duplicate; vp unchanged; target 0x300, counter 2'b01.
REQ-027 rst pulsed asynchronously mid-cycle with new_entry high -> all lookups miss immediately; vp=0; the write is dropped.
